// File: rtl/snake_grid_mp_if.sv
// rtl/snake_grid_mp_if.sv - Game-engine side signal bundle for the multi-snake occupancy grid
interface snake_grid_mp_if #(
   parameter int XW = 6,
   parameter int YW = 5,
   parameter int NS = 2,
   parameter int OW = 2,
   parameter int CW = 11
) ();
   logic                    clear_req;
   logic                    busy;
   logic                    tick;
   logic [NS-1:0]           alive;
   logic [NS*(XW+YW)-1:0]   head_xy;
   logic [NS*(XW+YW)-1:0]   tail_xy;
   logic [NS-1:0]           pop;
   logic [NS-1:0]           tail_valid;
   logic [NS*(XW+YW)-1:0]   next_xy;
   logic [XW-1:0]           q_x;
   logic [YW-1:0]           q_y;
   logic [OW-1:0]           q_owner;
   logic                    hit_valid;
   logic [NS*3-1:0]         hit_code;
   logic [CW-1:0]           occ_count;

   modport master (
      output clear_req, tick, alive, head_xy, tail_xy, pop, tail_valid, next_xy, q_x, q_y,
      input  busy, q_owner, hit_valid, hit_code, occ_count
   );

   modport slave (
      input  clear_req, tick, alive, head_xy, tail_xy, pop, tail_valid, next_xy, q_x, q_y,
      output busy, q_owner, hit_valid, hit_code, occ_count
   );
endinterface

// File: rtl/snake_grid_mp.sv
// rtl/snake_grid_mp.sv - Multi-snake owner-ID grid with tick commit, collision verdicts and row-sweep clear
module snake_grid_mp #(
   parameter int XW     = 6,
   parameter int YW     = 5,
   parameter int GRID_W = 40,
   parameter int GRID_H = 30,
   parameter int NS     = 2,
   parameter int OW     = 2,
   parameter int CW     = 11
) (
   input  logic            clk,
   input  logic            reset_n,
   snake_grid_mp_if.slave  bus
);
   localparam int              PW       = XW + YW;
   localparam logic [XW:0]     GW       = (XW+1)'(GRID_W);
   localparam logic [YW:0]     GH       = (YW+1)'(GRID_H);
   localparam logic [YW-1:0]   ROW_LAST = YW'(GRID_H - 1);
   localparam logic [CW-1:0]   ONE      = CW'(1);

   typedef enum logic {S_IDLE, S_CLEAR} state_e;

   state_e           state_q, state_d;
   logic [YW-1:0]    row_q, row_d;
   logic [OW-1:0]    cell_q [GRID_H][GRID_W];
   logic [CW-1:0]    occ_q, occ_d, add_n, sub_n;
   logic             hit_valid_q;
   logic [NS*3-1:0]  hit_code_q, hit_code_d;
   logic             do_tick;

   logic [XW-1:0]    hx [NS], tx [NS], nx [NS];
   logic [YW-1:0]    hy [NS], ty [NS], ny [NS];
   logic [OW-1:0]    h_own [NS], t_own [NS], n_own [NS];
   logic [NS-1:0]    h_in, t_in, n_in, head_wr, eff_pop;
   logic [NS-1:0]    head_on, freed, h_dup, t_cover;

   function automatic logic in_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return ({1'b0, x} < GW) && ({1'b0, y} < GH);
   endfunction

   function automatic logic [OW-1:0] rd_cell(input logic [XW-1:0] x, input logic [YW-1:0] y);
      if (in_grid(x, y)) return cell_q[y][x];
      return '0;
   endfunction

   assign do_tick = reset_n && bus.tick && (state_q == S_IDLE) && !bus.clear_req;

   always_comb begin
      for (int i = 0; i < NS; i++) begin
         hx[i] = bus.head_xy[i*PW+YW +: XW];
         hy[i] = bus.head_xy[i*PW +: YW];
         tx[i] = bus.tail_xy[i*PW+YW +: XW];
         ty[i] = bus.tail_xy[i*PW +: YW];
         nx[i] = bus.next_xy[i*PW+YW +: XW];
         ny[i] = bus.next_xy[i*PW +: YW];
      end
   end

   always_comb begin
      h_in    = '0;
      t_in    = '0;
      n_in    = '0;
      head_wr = '0;
      eff_pop = '0;
      for (int i = 0; i < NS; i++) begin
         h_in[i]    = in_grid(hx[i], hy[i]);
         t_in[i]    = in_grid(tx[i], ty[i]);
         n_in[i]    = in_grid(nx[i], ny[i]);
         h_own[i]   = rd_cell(hx[i], hy[i]);
         t_own[i]   = rd_cell(tx[i], ty[i]);
         n_own[i]   = rd_cell(nx[i], ny[i]);
         head_wr[i] = bus.alive[i] && h_in[i];
         // A snake may only pop a cell it actually owns.
         eff_pop[i] = bus.alive[i] && bus.pop[i] && bus.tail_valid[i] && t_in[i]
                      && (t_own[i] == OW'(i + 1));
      end
   end

   always_comb begin
      head_on = '0;
      freed   = '0;
      h_dup   = '0;
      t_cover = '0;
      for (int i = 0; i < NS; i++) begin
         for (int j = 0; j < NS; j++) begin
            if (j != i && bus.alive[j] && nx[j] == nx[i] && ny[j] == ny[i]) head_on[i] = 1'b1;
            if (eff_pop[j] && n_own[i] == OW'(j + 1) && tx[j] == nx[i] && ty[j] == ny[i])
               freed[i] = 1'b1;
            if (j > i && head_wr[j] && hx[j] == hx[i] && hy[j] == hy[i]) h_dup[i] = 1'b1;
            if (head_wr[j] && hx[j] == tx[i] && hy[j] == ty[i]) t_cover[i] = 1'b1;
         end
      end
   end

   always_comb begin
      hit_code_d = hit_code_q;
      add_n      = '0;
      sub_n      = '0;
      if (do_tick) begin
         hit_code_d = '0;
         for (int i = 0; i < NS; i++) begin
            if (bus.alive[i]) begin
               if (!n_in[i])                       hit_code_d[i*3 +: 3] = 3'd4;
               else if (head_on[i])                hit_code_d[i*3 +: 3] = 3'd3;
               else if (n_own[i] != '0 && !freed[i])
                  hit_code_d[i*3 +: 3] = (n_own[i] == OW'(i + 1)) ? 3'd1 : 3'd2;
            end
         end
      end
      // Duplicate heads count once; pops under a head write cancel against it.
      for (int i = 0; i < NS; i++) begin
         if (head_wr[i] && h_own[i] == '0 && !h_dup[i]) add_n = add_n + ONE;
         if (eff_pop[i] && !t_cover[i])               sub_n = sub_n + ONE;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      if (bus.clear_req) begin
         state_d = S_CLEAR;
         row_d   = '0;
      end else if (state_q == S_CLEAR) begin
         if (row_q == ROW_LAST) begin
            state_d = S_IDLE;
            row_d   = '0;
         end else begin
            row_d = row_q + 1'b1;
         end
      end
      occ_d = occ_q;
      if (state_d == S_CLEAR) occ_d = '0;
      else if (do_tick)       occ_d = occ_q + add_n - sub_n;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= S_CLEAR;
         row_q       <= '0;
         occ_q       <= '0;
         hit_valid_q <= 1'b0;
         hit_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         occ_q       <= occ_d;
         hit_valid_q <= do_tick;
         hit_code_q  <= hit_code_d;
      end
   end

   // Heads are written after pops, in index order, so later assignments win conflicts.
   always_ff @(posedge clk) begin
      if (state_q == S_CLEAR) begin
         for (int c = 0; c < GRID_W; c++) cell_q[row_q][c] <= '0;
      end else if (do_tick) begin
         for (int i = 0; i < NS; i++)
            if (eff_pop[i]) cell_q[ty[i]][tx[i]] <= '0;
         for (int i = 0; i < NS; i++)
            if (head_wr[i]) cell_q[hy[i]][hx[i]] <= OW'(i + 1);
      end
   end

   assign bus.busy      = (state_q == S_CLEAR);
   assign bus.q_owner   = rd_cell(bus.q_x, bus.q_y);
   assign bus.hit_valid = hit_valid_q;
   assign bus.hit_code  = hit_code_q;
   assign bus.occ_count = occ_q;
endmodule

// File: tb/tb_snake_grid_mp.sv
// tb/tb_snake_grid_mp.sv - Scoreboard bench for snake_grid_mp against a cell-array game model
module tb_snake_grid_mp;
   localparam int XW = 6, YW = 5, GW = 40, GH = 30, NS = 2, OW = 2, CW = 11;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   snake_grid_mp_if #(.XW(XW), .YW(YW), .NS(NS), .OW(OW), .CW(CW)) bus ();

   snake_grid_mp #(.XW(XW), .YW(YW), .GRID_W(GW), .GRID_H(GH), .NS(NS), .OW(OW), .CW(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int n_pass = 0;
   int n_chk  = 0;
   int mg [GH][GW];
   int exp_q [$];
   int al [NS], hxa [NS], hya [NS], txa [NS], tya [NS], pp [NS], tv [NS], nxa [NS], nya [NS];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.hit_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_hit_valid", 1, 0);
         else chk("hit_code", bus.hit_code, exp_q.pop_front());
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic bit inb(int x, int y);
      return x < GW && y < GH;
   endfunction

   function automatic int occ_model();
      int n = 0;
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++)
            if (mg[y][x] != 0) n++;
      return n;
   endfunction

   function automatic bit effpop(int i);
      return al[i] != 0 && pp[i] != 0 && tv[i] != 0 && inb(txa[i], tya[i])
             && mg[tya[i]][txa[i]] == i + 1;
   endfunction

   function automatic int verdict_word();
      int w = 0;
      for (int i = 0; i < NS; i++) begin
         int c = 0;
         if (al[i] != 0) begin
            bit clash = 0;
            for (int j = 0; j < NS; j++)
               if (j != i && al[j] != 0 && nxa[j] == nxa[i] && nya[j] == nya[i]) clash = 1;
            if (!inb(nxa[i], nya[i])) c = 4;
            else if (clash) c = 3;
            else begin
               int o = mg[nya[i]][nxa[i]];
               if (o != 0) begin
                  bit vacated = effpop(o - 1) && txa[o-1] == nxa[i] && tya[o-1] == nya[i];
                  if (!vacated) c = (o == i + 1) ? 1 : 2;
               end
            end
         end
         w = w | (c << (3 * i));
      end
      return w;
   endfunction

   task automatic apply_model();
      bit ep [NS];
      for (int i = 0; i < NS; i++) ep[i] = effpop(i);
      for (int i = 0; i < NS; i++) if (ep[i]) mg[tya[i]][txa[i]] = 0;
      for (int i = 0; i < NS; i++)
         if (al[i] != 0 && inb(hxa[i], hya[i])) mg[hya[i]][hxa[i]] = i + 1;
   endtask

   task automatic set_s(input int i, input int a, input int hx, input int hy, input int tx,
                        input int ty, input int p, input int t, input int nx, input int ny);
      al[i] = a; hxa[i] = hx; hya[i] = hy; txa[i] = tx; tya[i] = ty;
      pp[i] = p; tv[i] = t; nxa[i] = nx; nya[i] = ny;
   endtask

   task automatic drive_bus();
      for (int i = 0; i < NS; i++) begin
         bus.alive[i]             = al[i][0];
         bus.pop[i]               = pp[i][0];
         bus.tail_valid[i]        = tv[i][0];
         bus.head_xy[i*11 +: 11]  = {hxa[i][5:0], hya[i][4:0]};
         bus.tail_xy[i*11 +: 11]  = {txa[i][5:0], tya[i][4:0]};
         bus.next_xy[i*11 +: 11]  = {nxa[i][5:0], nya[i][4:0]};
      end
   endtask

   task automatic query(input int x, input int y);
      bus.q_x = x[5:0];
      bus.q_y = y[4:0];
      #1;
      chk("q_owner", bus.q_owner, inb(x, y) ? mg[y][x] : 0);
   endtask

   task automatic do_tick();
      drive_bus();
      bus.tick = 1'b1;
      exp_q.push_back(verdict_word());
      apply_model();
      @(posedge clk); #1;
      bus.tick = 1'b0;
      chk("occ_count", bus.occ_count, occ_model());
      for (int i = 0; i < NS; i++) query(hxa[i], hya[i]);
      query($urandom_range(0, 63), $urandom_range(0, 31));
   endtask

   task automatic count_busy(input string nm);
      int n = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.busy) n++;
         else break;
      end
      chk(nm, n, GH);
      @(posedge clk); #1;
   endtask

   task automatic grid_zero(input string nm);
      int nz = 0;
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++) begin
            bus.q_x = x[5:0];
            bus.q_y = y[4:0];
            #1;
            if (bus.q_owner !== 2'd0) nz++;
         end
      chk(nm, nz, 0);
      chk("occ_after_clear", bus.occ_count, 0);
      for (int y = 0; y < GH; y++)
         for (int x = 0; x < GW; x++) mg[y][x] = 0;
      @(posedge clk); #1;
   endtask

   function automatic int rnd_x();
      int r = $urandom_range(0, 15);
      return (r < 14) ? (r % 8) : $urandom_range(40, 63);
   endfunction

   function automatic int rnd_y();
      int r = $urandom_range(0, 15);
      return (r < 14) ? (r % 6) : $urandom_range(30, 31);
   endfunction

   initial begin
      bus.clear_req = 1'b0; bus.tick = 1'b0; bus.q_x = '0; bus.q_y = '0;
      for (int i = 0; i < NS; i++) set_s(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive_bus();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", bus.busy, 1);
      chk("reset_hit_valid", bus.hit_valid, 0);
      chk("reset_hit_code", bus.hit_code, 0);
      chk("reset_occ", bus.occ_count, 0);
      reset_n = 1'b1;
      count_busy("busy_after_reset");
      grid_zero("grid_zero_after_reset");

      set_s(0, 1, 5, 5, 0, 0, 0, 0, 6, 5);  do_tick();
      set_s(0, 1, 6, 5, 5, 5, 0, 1, 7, 5);  do_tick();
      set_s(0, 1, 6, 5, 5, 5, 1, 1, 5, 5);  do_tick();
      set_s(0, 1, 5, 5, 0, 0, 0, 0, 4, 5);  do_tick();
      set_s(0, 1, 6, 5, 5, 5, 0, 1, 5, 5);  do_tick();
      set_s(0, 1, 6, 5, 0, 0, 0, 0, 10, 10);
      set_s(1, 1, 20, 20, 0, 0, 0, 0, 10, 10);  do_tick();
      set_s(0, 1, 6, 5, 0, 0, 0, 0, 11, 12);
      set_s(1, 1, 20, 21, 5, 5, 1, 1, 6, 5);    do_tick();
      set_s(0, 1, 40, 3, 40, 3, 1, 1, 40, 3);
      set_s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);      do_tick();
      query(40, 3);
      query(63, 31);

      bus.clear_req = 1'b1;
      @(posedge clk); #1;
      bus.clear_req = 1'b0;
      for (int k = 0; k < 11; k++) begin
         bus.tick = (k % 3 == 0);
         @(posedge clk); #1;
      end
      bus.clear_req = 1'b1;
      bus.tick = 1'b1;
      @(posedge clk); #1;
      bus.clear_req = 1'b0;
      bus.tick = 1'b0;
      count_busy("busy_after_restart");
      grid_zero("grid_zero_after_restart");

      for (int t = 0; t < 200; t++) begin
         for (int i = 0; i < NS; i++)
            set_s(i, $urandom_range(0, 3) != 0, rnd_x(), rnd_y(), rnd_x(), rnd_y(),
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0, rnd_x(), rnd_y());
         do_tick();
         if ($urandom_range(0, 2) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/snake_grid_mp.md
Name: snake_grid_mp

Overview:
- Multi-snake occupancy grid for the game step engine; the successor to the single-snake occupancy map.
- Each cell stores an owner ID: 0 = empty, 1..NS = snake index + 1.
- On each game tick it commits head writes and tail pops for every alive snake. One cycle later it returns a registered collision verdict per snake: wall, head-on, self or other.
- A row-sweep clear FSM replaces the bulk array reset. The renderer reads the grid through a combinational query port.

Parameters:
- XW, 6, x coordinate width
- YW, 5, y coordinate width
- GRID_W, 40, columns (must be <= 2^XW)
- GRID_H, 30, rows (must be <= 2^YW)
- NS, 2, number of snakes (1..2^OW-1)
- OW, 2, owner-ID width per cell
- CW, 11, occupied-cell counter width (2^CW > GRID_W*GRID_H)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- clear_req  in  1  pulse: start a grid clear sweep
- busy  out  1  high while the clear sweep runs
- tick  in  1  one pulse per game step
- alive  in  NS  per-snake enable; a dead snake neither writes nor is checked
- head_xy  in  NS*(XW+YW)  per snake {x,y} of the current head, which becomes body on tick; snake i is in slice i
- tail_xy  in  NS*(XW+YW)  per snake {x,y} of the tail to pop
- pop  in  NS  per snake: pop the tail this tick (not eating)
- tail_valid  in  NS  per snake: tail_xy is meaningful
- next_xy  in  NS*(XW+YW)  per snake {x,y} of the proposed next head
- q_x  in  XW  draw query column
- q_y  in  YW  draw query row
- q_owner  out  OW  owner of cell (q_x,q_y); combinational; 0 if out of bounds
- hit_valid  out  1  one-cycle pulse carrying verdicts for the preceding tick
- hit_code  out  NS*3  per snake: 0 none, 1 self, 2 other, 3 head-on, 4 wall
- occ_count  out  CW  number of non-empty cells

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - busy=1, hit_valid=0, hit_code=0, occ_count=0.
  - FSM enters CLEAR with row=0.
  - Grid contents are not reset directly.
- FSM states: IDLE and CLEAR.
  - CLEAR writes one row of zeros per cycle at row index 0..GRID_H-1.
  - After the write at row GRID_H-1 the FSM goes to IDLE and busy drops on the next cycle. busy is high for exactly GRID_H cycles.
  - occ_count is held at 0 throughout CLEAR.
- clear_req:
  - In IDLE: enter CLEAR with row=0.
  - In CLEAR: restart the sweep at row=0.
  - reset_n=0 mid-sweep also restarts the sweep.
- tick during CLEAR (or in the same cycle as clear_req) is ignored: no writes and no hit_valid.
- Tick commit in IDLE, for each snake i with alive[i]=1:
  - cell[head_i] <= i+1.
  - If pop[i] && tail_valid[i] && cell[tail_i]==i+1, then cell[tail_i] <= 0. A pop of a cell the snake does not own is suppressed.
- Write conflicts within one tick:
  - A head write beats any tail pop on the same cell.
  - If two heads write the same cell, the higher index wins.
- occ_count update per tick: add the number of head writes to previously empty cells; subtract the number of effective pops not overwritten by a head. Compute it from pre-tick cell values.
- Verdict per alive snake, evaluated on pre-tick grid contents and registered: hit_code and hit_valid appear the cycle after tick. Priority, highest first:
  - wall: next_x >= GRID_W or next_y >= GRID_H.
  - head-on: next_i equals next_j for some other alive j.
  - occupied: owner o = cell[next_i] is non-zero, and the cell is not freed this tick by its owner's effective pop. Code is self if o==i+1, else other.
  - none.
- Dead snakes always report code 0.
- Out-of-bounds head or tail coordinates are never written.
- hit_code holds its value until the next hit_valid; it returns to 0 on reset.

Test Plan:
- Release reset with GRID_H=30 -> busy=1 for exactly 30 cycles, then 0. All q_owner=0 and occ_count=0.
- After the sweep, tick with alive=01, head0=(5,5), pop=0 -> next cycle hit_valid=1 and hit_code[0]=0. q_owner(5,5)=1 and occ_count=1.
- Snake 0 body at (6,5),(5,5), tail=(5,5), pop=1, next=(5,5) -> hit_code[0]=0 (tail chase allowed). With pop=0 the same stimulus -> hit_code[0]=1.
- Both alive, next0=next1=(10,10) -> hit_code = {3,3}. Snake 1 next on snake 0's non-popping body -> hit_code[1]=2.
- next0=(40,3) -> hit_code[0]=4, and no write outside the grid.
- Assert clear_req at cycle 12 of a sweep, with tick pulses inside it -> sweep restarts and busy lasts 30 further cycles. No hit_valid during the sweep; the grid ends all zero.
